// File: rtl/jesd207_tx_framer.sv
// jesd207_tx_framer: pops I/Q entries from the JESD207 FIFO and serialises them onto the SDR TX bus.
// Optional pair/underrun statistics counters are enabled by defining JESD207_TX_STAT_EN.
module jesd207_tx_framer #(
    parameter int SAMPLE_WID = 12,
    parameter int ENTRY_WID  = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en,
    input  logic                  rempty,
    output logic                  rinc,
    input  logic [ENTRY_WID-1:0]  rdata,
    output logic                  tx_frame,
    output logic [SAMPLE_WID-1:0] tx_data,
    output logic                  tx_active,
    output logic                  underrun,
    input  logic                  underrun_clr
`ifdef JESD207_TX_STAT_EN
    ,
    input  logic                  stat_clr,
    output logic [15:0]           pair_cnt,
    output logic [7:0]            urun_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, FILL, TX_I, TX_Q} state_t;
    state_t state, state_d;
    logic [SAMPLE_WID-1:0] q_hold, hold_d, data_d;
    logic frame_d, pend, pend_d, urun_evt;
    assign tx_active = state == TX_I || state == TX_Q;
    assign urun_evt  = state == TX_I && tx_en && rempty;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx_frame <= 1'b0;
            tx_data  <= '0;
            q_hold   <= '0;
            pend     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state    <= state_d;
            tx_frame <= frame_d;
            tx_data  <= data_d;
            q_hold   <= hold_d;
            pend     <= pend_d;
            underrun <= urun_evt || (underrun && !underrun_clr);
        end
    end
    // pend remembers a pop made in TX_I so TX_Q can chain the next pair without a gap
    always_comb begin
        state_d = state;
        frame_d = tx_frame;
        data_d  = tx_data;
        hold_d  = q_hold;
        pend_d  = 1'b0;
        rinc    = !rst && !rempty && tx_en && (state == IDLE || state == TX_I);
        case (state)
            IDLE: begin
                frame_d = 1'b0;
                data_d  = '0;
                state_d = rinc ? FILL : IDLE;
            end
            FILL: begin
                frame_d = 1'b1;
                data_d  = rdata[ENTRY_WID-1:SAMPLE_WID];
                hold_d  = rdata[SAMPLE_WID-1:0];
                state_d = TX_I;
            end
            TX_I: begin
                frame_d = 1'b0;
                data_d  = q_hold;
                pend_d  = rinc;
                state_d = TX_Q;
            end
            default: begin
                frame_d = pend;
                data_d  = pend ? rdata[ENTRY_WID-1:SAMPLE_WID] : '0;
                hold_d  = pend ? rdata[SAMPLE_WID-1:0] : q_hold;
                state_d = pend ? TX_I : IDLE;
            end
        endcase
    end
`ifdef JESD207_TX_STAT_EN
    logic pair_evt;
    assign pair_evt = state == TX_Q;
    always_ff @(posedge clk) begin
        if (rst) begin
            pair_cnt <= '0;
            urun_cnt <= '0;
        end else begin
            pair_cnt <= stat_clr ? 16'(pair_evt) : pair_cnt + 16'(pair_evt);
            urun_cnt <= stat_clr ? 8'(urun_evt) : urun_cnt + 8'(urun_evt);
        end
    end
`endif
endmodule

// File: tb/tb_jesd207_tx_framer.sv
// tb_jesd207_tx_framer: directed bench for jesd207_tx_framer with a FIFO/RAM read-side model.
module tb_jesd207_tx_framer;
    logic clk = 1'b0, rst = 1'b1, tx_en = 1'b0, underrun_clr = 1'b0;
    logic rinc, rempty, tx_frame, tx_active, underrun;
    logic [23:0] rdata = '0;
    logic [11:0] tx_data;
    logic [23:0] mem [0:63];
    int wr_cnt = 0, rd_cnt = 0, total = 0, fails = 0;
`ifdef JESD207_TX_STAT_EN
    logic stat_clr = 1'b0;
    logic [15:0] pair_cnt;
    logic [7:0] urun_cnt;
`endif
    jesd207_tx_framer #(.SAMPLE_WID(12), .ENTRY_WID(24)) dut (
        .clk(clk), .rst(rst), .tx_en(tx_en), .rempty(rempty), .rinc(rinc),
        .rdata(rdata), .tx_frame(tx_frame), .tx_data(tx_data),
        .tx_active(tx_active), .underrun(underrun), .underrun_clr(underrun_clr)
`ifdef JESD207_TX_STAT_EN
        , .stat_clr(stat_clr), .pair_cnt(pair_cnt), .urun_cnt(urun_cnt)
`endif
    );
    always #5 clk = ~clk;
    assign rempty = wr_cnt == rd_cnt;
    always @(posedge clk) if (rinc) begin
        rdata  <= mem[rd_cnt[5:0]];
        rd_cnt <= rd_cnt + 1;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic bus(input string tag, input logic f, input logic [11:0] d, input logic a);
        chk({tag, ".frame"}, 32'(tx_frame), 32'(f));
        chk({tag, ".data"}, 32'(tx_data), 32'(d));
        chk({tag, ".active"}, 32'(tx_active), 32'(a));
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [23:0] e);
        mem[wr_cnt[5:0]] = e;
        wr_cnt++;
    endtask
    initial begin
        tick; tick;
        bus("rst", 1'b0, 12'h000, 1'b0);
        chk("rst.underrun", 32'(underrun), 0);
        push(24'h111222); push(24'hABC123); push(24'hFFF000);
        tx_en = 1'b1;
        #1 chk("rst.rinc_held", 32'(rinc), 0);
        tick;
        rst = 1'b0;
        #1 chk("t1.c0.rinc", 32'(rinc), 1);
        tick; chk("t1.c1.rinc", 32'(rinc), 0); bus("t1.c1", 1'b0, 12'h000, 1'b0);
        tick; chk("t1.c2.rinc", 32'(rinc), 1); bus("t1.c2", 1'b1, 12'h111, 1'b1);
        tick; chk("t1.c3.rinc", 32'(rinc), 0); bus("t1.c3", 1'b0, 12'h222, 1'b1);
        tick; chk("t1.c4.rinc", 32'(rinc), 1); bus("t1.c4", 1'b1, 12'hABC, 1'b1);
        tick; bus("t1.c5", 1'b0, 12'h123, 1'b1);
        tick; chk("t1.c6.rinc", 32'(rinc), 0); bus("t1.c6", 1'b1, 12'hFFF, 1'b1);
        chk("t1.c6.underrun", 32'(underrun), 0);
        underrun_clr = 1'b1;
        tick; bus("t1.c7", 1'b0, 12'h000, 1'b1); chk("t1.c7.set_wins", 32'(underrun), 1);
        underrun_clr = 1'b0;
        tick; bus("t1.c8", 1'b0, 12'h000, 1'b0); chk("t1.c8.underrun", 32'(underrun), 1);
        underrun_clr = 1'b1;
        tick; chk("t1.c9.cleared", 32'(underrun), 0);
        underrun_clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick;
            chk("t2.rinc", 32'(rinc), 0);
            bus("t2", 1'b0, 12'h000, 1'b0);
            chk("t2.underrun", 32'(underrun), 0);
        end
        push(24'hABC123);
        #1 chk("t3.a0.rinc", 32'(rinc), 1);
        tick; push(24'h111222);
        tick; chk("t3.a2.rinc", 32'(rinc), 1); bus("t3.a2", 1'b1, 12'hABC, 1'b1);
        tick; bus("t3.a3", 1'b0, 12'h123, 1'b1);
        tick; bus("t3.a4", 1'b1, 12'h111, 1'b1);
        tx_en = 1'b0;
        #1 chk("t3.a4.rinc_off", 32'(rinc), 0);
        push(24'hFFF000);
        tick; bus("t3.a5", 1'b0, 12'h222, 1'b1); chk("t3.a5.underrun", 32'(underrun), 0);
        tick; bus("t3.a6", 1'b0, 12'h000, 1'b0); chk("t3.a6.underrun", 32'(underrun), 0);
        chk("t3.a6.rinc", 32'(rinc), 0);
        tick; chk("t3.a7.rinc", 32'(rinc), 0); bus("t3.a7", 1'b0, 12'h000, 1'b0);
        push(24'hABC123);
        tx_en = 1'b1;
        #1 chk("t4.b0.rinc", 32'(rinc), 1);
        tick;
        tick; chk("t4.b2.rinc", 32'(rinc), 1); bus("t4.b2", 1'b1, 12'hFFF, 1'b1);
        tick; bus("t4.b3", 1'b0, 12'h000, 1'b1);
        rst = 1'b1;
        tick; bus("t4.b4", 1'b0, 12'h000, 1'b0); chk("t4.b4.rinc", 32'(rinc), 0);
        rst = 1'b0;
        push(24'h111222);
        #1 chk("t4.b4.rinc_new", 32'(rinc), 1);
        tick; bus("t4.b5", 1'b0, 12'h000, 1'b0);
        tick; bus("t4.b6", 1'b1, 12'h111, 1'b1); chk("t4.b6.rinc", 32'(rinc), 0);
        tick; bus("t4.b7", 1'b0, 12'h222, 1'b1); chk("t4.b7.underrun", 32'(underrun), 1);
        tick; bus("t4.b8", 1'b0, 12'h000, 1'b0);
`ifdef JESD207_TX_STAT_EN
        chk("stat.pair_cnt", 32'(pair_cnt), 1);
        chk("stat.urun_cnt", 32'(urun_cnt), 1);
        stat_clr = 1'b1;
        tick; stat_clr = 1'b0;
        chk("stat.pair_clr", 32'(pair_cnt), 0);
        chk("stat.urun_clr", 32'(urun_cnt), 0);
`endif
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
